div_iter: RTL

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per clock.
// Result is packed as {remainder, quotient}. Signed mode works on operand
// magnitudes and corrects the signs once the last quotient bit is in.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op1_r;     // captured dividend (raw, signed or not)
    logic [WIDTH-1:0] op2_r;     // captured divisor (raw)
    logic             sgn_r;     // captured signed_div_i
    logic [WIDTH-1:0] quo;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   rem;       // partial remainder

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] cur;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             q_bit;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Magnitudes, one restoring step and the final sign correction.
    always_comb begin
        dvd_mag = (sgn_r && op1_r[WIDTH-1]) ? (~op1_r + 1'b1) : op1_r;
        dvs_mag = (sgn_r && op2_r[WIDTH-1]) ? (~op2_r + 1'b1) : op2_r;
        // The first step pulls dividend bits straight from the captured
        // magnitude; after that the quotient register carries what is left.
        cur     = (cnt == '0) ? dvd_mag : quo;
        shifted = {rem[WIDTH-1:0], cur[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_mag};
        q_bit   = ~diff[WIDTH+1];
        neg_q   = sgn_r & (op1_r[WIDTH-1] ^ op2_r[WIDTH-1]);
        neg_r   = sgn_r & op1_r[WIDTH-1];
        // MIN / -1 wraps back to MIN here without any special case.
        q_fix   = neg_q ? (~quo + 1'b1) : quo;
        r_fix   = neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            op1_r    <= '0;
            op2_r    <= '0;
            sgn_r    <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        op1_r <= opdata1_i;
                        op2_r <= opdata2_i;
                        sgn_r <= signed_div_i;
                        cnt   <= '0;
                        quo   <= '0;
                        rem   <= '0;
                        state <= (opdata2_i == '0) ? BY_ZERO : ON;
                    end
                end
                BY_ZERO: begin
                    result_o <= '0;
                    if (annul_i) begin
                        ready_o <= 1'b0;
                        state   <= FREE;
                    end else begin
                        ready_o <= 1'b1;
                        state   <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        state    <= FREE;
                    end else if (cnt != CNT_LAST) begin
                        quo <= {cur[WIDTH-2:0], q_bit};
                        rem <= q_bit ? diff[WIDTH:0] : shifted;
                        cnt <= cnt + 1'b1;
                    end else begin
                        result_o <= {r_fix, q_fix};
                        ready_o  <= 1'b1;
                        state    <= END;
                    end
                end
                END: begin
                    // Result is held until the requester drops start_i.
                    if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        state    <= FREE;
                    end
                end
                default: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    state    <= FREE;
                end
            endcase
        end
    end

endmodule
